// File: rtl/conv_seq_ctrl.sv
// Sequencer that feeds a packed N-digit word through one shared 4-bit converter,
// LSB nibble first, and reassembles the converted word behind a valid/ready handshake.
module conv_seq_ctrl #(
    parameter int unsigned N_DIGITS = 4,
    localparam int unsigned IDX_W = $clog2(N_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*N_DIGITS-1:0] din,
    input  logic                  stall,
    output logic                  busy,
    output logic [3:0]            conv_in,
    input  logic [3:0]            conv_out,
    output logic [IDX_W-1:0]      digit_idx,
    output logic [4*N_DIGITS-1:0] dout,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_DIGITS - 1);

    state_e                state_q, state_d;
    logic [4*N_DIGITS-1:0] hold_q, hold_d;
    logic [4*N_DIGITS-1:0] dout_q, dout_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  out_valid_q, out_valid_d;
    logic [3:0]            cur_nib;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        dout_d      = dout_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;

        // Select the held nibble addressed by the digit index.
        cur_nib = 4'h0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nib = hold_q[4*k +: 4];
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    hold_d  = din;
                    idx_d   = '0;
                    state_d = StConv;
                end
            end
            StConv: begin
                if (!stall) begin
                    for (int unsigned k = 0; k < N_DIGITS; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            dout_d[4*k +: 4] = conv_out;
                        end
                    end
                    if (idx_q == LastIdx) begin
                        idx_d       = '0;
                        out_valid_d = 1'b1;
                        state_d     = StDone;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    // A start alongside the handshake chains straight into the next word.
                    if (start) begin
                        hold_d  = din;
                        idx_d   = '0;
                        state_d = StConv;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d     = StIdle;
                out_valid_d = 1'b0;
                idx_d       = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            dout_q      <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            dout_q      <= dout_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign conv_in   = (state_q == StConv) ? cur_nib : 4'h0;
    assign busy      = (state_q != StIdle);
    assign digit_idx = idx_q;
    assign dout      = dout_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
Sequencer that time-shares one 4-bit combinational code converter across a packed multi-digit word. It accepts an N-nibble word on a start strobe and drives the nibbles through the converter one per cycle, LSB nibble first. It reassembles the converted nibbles into an output word and presents the result with a valid/ready handshake. The block sits between the digit source and the shared converter; the converter itself stays outside this block.

Parameters:
N_DIGITS, 4, number of 4-bit nibbles per word; legal range 2..16.
IDX_W, $clog2(N_DIGITS), width of the digit index counter; derived, never overridden.

Ports:
clk  input  1  single system clock; all state updates on the rising edge.
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
start  input  1  request to convert din; sampled only when the block can accept.
din  input  4*N_DIGITS  packed input word; nibble k is din[4k+3:4k].
stall  input  1  when high in CONV, freezes the index and skips the capture.
busy  output  1  high in CONV and DONE.
conv_in  output  4  nibble driven to the external converter.
conv_out  input  4  converter result; combinational response to conv_in in the same cycle.
digit_idx  output  IDX_W  index of the nibble currently on conv_in.
dout  output  4*N_DIGITS  converted word; nibble k is the conversion of din nibble k.
out_valid  output  1  dout is complete and stable.
out_ready  input  1  consumer accepts dout.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE; busy, out_valid, digit_idx, conv_in and dout all go to 0; the captured word is cleared.
- Reset mid-operation (CONV or DONE) aborts the operation: no out_valid pulse and no partial dout.
- States: IDLE, CONV, DONE; 2-bit encoded register.
- IDLE:
  - busy=0, out_valid=0, conv_in=0.
  - start=1 -> capture din into a holding register, digit_idx=0, go to CONV.
- CONV:
  - conv_in = held nibble[digit_idx] (combinational mux from the holding register).
  - Each edge with stall=0: dout nibble[digit_idx] <= conv_out, then digit_idx increments.
  - On the edge that writes nibble N_DIGITS-1: digit_idx returns to 0, out_valid <= 1, go to DONE.
  - stall=1: no capture, digit_idx holds, conv_in holds.
  - start is ignored in CONV; din changes have no effect after capture.
- DONE:
  - out_valid=1, busy=1, conv_in=0; dout stable until the handshake completes.
  - out_ready=1 and start=0 -> out_valid <= 0, go to IDLE.
  - out_ready=1 and start=1 in the same cycle -> capture the new din, out_valid <= 0, go to CONV (back-to-back, no IDLE bubble).
  - out_ready=0 -> hold indefinitely; start is ignored.
- dout holds its last value after the handshake until the next conversion overwrites it nibble by nibble. Nibbles not yet rewritten keep their old values; consumers use dout only while out_valid=1.
- Latency: the start-sampling edge is T0. With no stall, out_valid rises at edge T0+N_DIGITS. Each stall cycle in CONV adds one cycle.
- Throughput: one word per N_DIGITS+1 cycles with out_ready held high and start held high.
- The converter path is purely combinational: conv_in is registered-state-derived, and conv_out is captured on the same edge.

Test Plan:
- Bench converter stub conv_out = ~conv_in, N_DIGITS=4. Pulse start with din=16'h1234 -> out_valid high 4 cycles after start, dout=16'hEDCB. digit_idx sequence 0,1,2,3 on the 4 CONV cycles, conv_in sequence 4,3,2,1.
- Same stimulus with stall=1 for 2 cycles while digit_idx=1 -> out_valid rises at T0+6. dout=16'hEDCB; digit_idx holds at 1 during the stall.
- DONE with out_ready=0 for 5 cycles, start=1 and din=16'hFFFF toggled meanwhile -> dout stays 16'hEDCB and out_valid stays 1. Then out_ready=1 with start=0 -> out_valid=0 and busy=0 next cycle.
- Back-to-back: in DONE drive out_ready=1 with start=1 and din=16'h0A5F -> next cycle state CONV and out_valid=0. Four cycles later out_valid=1 and dout=16'hF5A0.
- rst_n=0 for one edge while digit_idx=2 in CONV -> next cycle busy=0, out_valid=0, dout=0, conv_in=0. A following start with din=16'h0001 -> dout=16'hFFFE.
- start while in CONV (din=16'h9999) -> ignored: the current result is unaffected, and no second conversion follows without a fresh start.
